// File: rtl/rv_exec_mdu_alu_if.sv
// rv_exec_mdu_alu_if: issue/result bundle between decode, the execute ALU and writeback.
interface rv_exec_mdu_alu_if #(parameter int XLEN = 32);
  logic in_valid, in_ready, flush, out_valid, busy;
  logic [4:0] op, rd_in, out_rd;
  logic [XLEN-1:0] a, b, out_c;
  modport master(output in_valid, op, a, b, rd_in, flush, input in_ready, out_valid, out_rd, out_c, busy);
  modport slave(input in_valid, op, a, b, rd_in, flush, output in_ready, out_valid, out_rd, out_c, busy);
endinterface

// File: rtl/rv_exec_mdu_alu.sv
// rv_exec_mdu_alu: XLEN 32/64 execute ALU with iterative M-extension multiply/divide.
// Define RV_EXEC_MDU_FAST_MUL_EN for a single-cycle combinational multiplier.
module rv_exec_mdu_alu #(
  parameter int XLEN = 32,
  parameter int MUL_BITS = 2
) (
  input logic clk,
  input logic reset_n,
  rv_exec_mdu_alu_if.slave io
);
  localparam int SW = $clog2(XLEN);
  localparam int MUL_ITERS = XLEN / MUL_BITS;
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  state_t state_q, state_d;
  logic [6:0] cnt_q, cnt_d;
  logic [4:0] op_q, op_d, rd_q, rd_d, out_rd_q, out_rd_d;
  logic [2*XLEN-1:0] acc_q, acc_d, mcand_q, mcand_d;
  logic [XLEN-1:0] mplier_q, mplier_d, quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d, out_c_q, out_c_d;
  logic nq_q, nq_d, nr_q, nr_d, out_valid_q, out_valid_d;
  logic accept, is_mul, is_div, a_sgn, b_sgn, d_sgn, a_neg, b_neg, ge;
  logic [2*XLEN-1:0] a_ext, fast_p, part;
  logic [XLEN-1:0] alu_c, a_mag, b_mag, q_fix, r_fix, done_c;
  logic [XLEN:0] rs;
  logic [SW-1:0] shamt;
  assign accept = io.in_valid & io.in_ready & ~io.flush;
  assign is_mul = io.op inside {[5'd10:5'd13]};
  assign is_div = io.op inside {[5'd14:5'd17]};
  assign a_sgn = io.op inside {5'd10, 5'd11, 5'd12};
  assign b_sgn = io.op inside {5'd10, 5'd11};
  assign d_sgn = io.op inside {5'd14, 5'd16};
  assign a_ext = {{XLEN{a_sgn & io.a[XLEN-1]}}, io.a};
`ifdef RV_EXEC_MDU_FAST_MUL_EN
  localparam bit FAST_MUL = 1'b1;
  logic [2*XLEN-1:0] b_ext;
  assign b_ext = {{XLEN{b_sgn & io.b[XLEN-1]}}, io.b};
  assign fast_p = a_ext * b_ext;
`else
  localparam bit FAST_MUL = 1'b0;
  assign fast_p = '0;
`endif
  assign a_neg = d_sgn & io.a[XLEN-1];
  assign b_neg = d_sgn & io.b[XLEN-1];
  assign a_mag = a_neg ? -io.a : io.a;
  assign b_mag = b_neg ? -io.b : io.b;
  assign shamt = io.b[SW-1:0];
  assign rs = {rem_q, quo_q[XLEN-1]};
  assign ge = rs >= {1'b0, dvs_q};
  assign q_fix = nq_q ? -quo_q : quo_q;
  assign r_fix = nr_q ? -rem_q : rem_q;
  assign done_c = op_q == 5'd10 ? acc_q[XLEN-1:0] :
                  op_q inside {[5'd11:5'd13]} ? acc_q[2*XLEN-1:XLEN] :
                  op_q inside {5'd14, 5'd15} ? q_fix : r_fix;
  always_comb begin
    case (io.op)
      5'd0: alu_c = io.a + io.b;
      5'd1: alu_c = io.a - io.b;
      5'd2: alu_c = io.a & io.b;
      5'd3: alu_c = io.a | io.b;
      5'd4: alu_c = io.a ^ io.b;
      5'd5: alu_c = io.a << shamt;
      5'd6: alu_c = io.a >> shamt;
      5'd7: alu_c = $signed(io.a) >>> shamt;
      5'd8: alu_c = {{(XLEN-1){1'b0}}, $signed(io.a) < $signed(io.b)};
      5'd9: alu_c = {{(XLEN-1){1'b0}}, io.a < io.b};
      5'd10: alu_c = fast_p[XLEN-1:0];
      5'd11, 5'd12, 5'd13: alu_c = fast_p[2*XLEN-1:XLEN];
      default: alu_c = '0;
    endcase
  end
  // Radix-2^MUL_BITS partial product: shifted multiplicand copies for each set multiplier bit.
  always_comb begin
    part = '0;
    for (int i = 0; i < MUL_BITS; i++) part = mplier_q[i] ? part + (mcand_q << i) : part;
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    op_d = op_q;
    rd_d = rd_q;
    acc_d = acc_q;
    mcand_d = mcand_q;
    mplier_d = mplier_q;
    quo_d = quo_q;
    rem_d = rem_q;
    dvs_d = dvs_q;
    nq_d = nq_q;
    nr_d = nr_q;
    out_valid_d = 1'b0;
    out_rd_d = out_rd_q;
    out_c_d = out_c_q;
    case (state_q)
      IDLE: if (accept) begin
        op_d = io.op;
        rd_d = io.rd_in;
        cnt_d = '0;
        if (is_mul && !FAST_MUL) begin
          state_d = MUL;
          // Multiplier bits are consumed unsigned; a negative signed rs2 is pre-corrected here.
          acc_d = (b_sgn & io.b[XLEN-1]) ? -(a_ext << XLEN) : '0;
          mcand_d = a_ext;
          mplier_d = io.b;
        end else if (is_div) begin
          state_d = DONE;
          nq_d = 1'b0;
          nr_d = 1'b0;
          if (io.b == '0) begin
            quo_d = '1;
            rem_d = io.a;
          end else if (d_sgn && io.a == {1'b1, {(XLEN-1){1'b0}}} && io.b == '1) begin
            quo_d = io.a;
            rem_d = '0;
          end else begin
            state_d = DIV;
            quo_d = a_mag;
            rem_d = '0;
            dvs_d = b_mag;
            nq_d = a_neg ^ b_neg;
            nr_d = a_neg;
          end
        end else begin
          out_valid_d = 1'b1;
          out_rd_d = io.rd_in;
          out_c_d = alu_c;
        end
      end
      MUL: begin
        acc_d = acc_q + part;
        mcand_d = mcand_q << MUL_BITS;
        mplier_d = mplier_q >> MUL_BITS;
        cnt_d = cnt_q + 7'd1;
        state_d = cnt_q == 7'(MUL_ITERS - 1) ? DONE : MUL;
      end
      DIV: begin
        rem_d = ge ? XLEN'(rs - {1'b0, dvs_q}) : rs[XLEN-1:0];
        quo_d = {quo_q[XLEN-2:0], ge};
        cnt_d = cnt_q + 7'd1;
        state_d = cnt_q == 7'(XLEN - 1) ? DONE : DIV;
      end
      default: begin
        state_d = IDLE;
        out_valid_d = 1'b1;
        out_rd_d = rd_q;
        out_c_d = done_c;
      end
    endcase
    if (io.flush) begin
      state_d = IDLE;
      out_valid_d = 1'b0;
      out_rd_d = out_rd_q;
      out_c_d = out_c_q;
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      op_q <= '0;
      rd_q <= '0;
      acc_q <= '0;
      mcand_q <= '0;
      mplier_q <= '0;
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
      nq_q <= 1'b0;
      nr_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_rd_q <= '0;
      out_c_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      op_q <= op_d;
      rd_q <= rd_d;
      acc_q <= acc_d;
      mcand_q <= mcand_d;
      mplier_q <= mplier_d;
      quo_q <= quo_d;
      rem_q <= rem_d;
      dvs_q <= dvs_d;
      nq_q <= nq_d;
      nr_q <= nr_d;
      out_valid_q <= out_valid_d;
      out_rd_q <= out_rd_d;
      out_c_q <= out_c_d;
    end
  end
  assign io.in_ready = state_q == IDLE;
  assign io.busy = state_q != IDLE;
  assign io.out_valid = out_valid_q & ~io.flush;
  assign io.out_rd = out_rd_q;
  assign io.out_c = out_c_q;
endmodule
